vga_sync_monitor: RTL

//  Receive-side checker for the VGA timing generated by the 1024x768 driver: samples VGA_HS/VGA_VS in the clk_vga domain.

---
 rtl/vga_sync_monitor.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Receive-side checker for VGA sync timing. Samples the horizontal and
//   vertical sync pins in the pixel clock domain, measures the line period,
//   the hsync width and the frame length, and rebuilds the pixel position
//   from the syncs alone. Lock is declared after LOCK_FRAMES consecutive
//   good frames; loss of lock raises a single-cycle error pulse.
//
//   Ports
//     clk_vga      pixel clock, all logic on its rising edge
//     rst_n        asynchronous reset, active-low
//     vga_hs       horizontal sync pin, active level set by SYNC_POL
//     vga_vs       vertical sync pin, active level set by SYNC_POL
//     hc_meas      last measured line period (clocks)
//     hs_width     last measured hsync active width (clocks)
//     vc_meas      last measured frame length (lines)
//     h_pos        clocks since last hsync leading edge, 0 while unlocked
//     v_pos        lines since last vsync leading edge, 0 while unlocked
//     frame_start  1-cycle pulse on a vsync leading edge while locked
//     locked       timing matches H_TOTAL / V_TOTAL
//     sync_err     1-cycle pulse when lock is lost
//
//   The sync inputs carry no handshake: every clock edge samples both pins
//   and all derived events (edges, measurements, state changes) take effect
//   two edges after a pin change is first captured.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 1344,
  parameter int V_TOTAL     = 806,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2,
  parameter int CW          = 11
) (
  input  logic          clk_vga,
  input  logic          rst_n,
  input  logic          vga_hs,
  input  logic          vga_vs,
  output logic [CW-1:0] hc_meas,
  output logic [CW-1:0] hs_width,
  output logic [CW-1:0] vc_meas,
  output logic [CW-1:0] h_pos,
  output logic [CW-1:0] v_pos,
  output logic          frame_start,
  output logic          locked,
  output logic          sync_err
);

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] H_T    = CW'(H_TOTAL);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_T    = CW'(V_TOTAL);
  localparam logic [3:0]    LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + ONE;
  endfunction

  // Input stage: pins folded to active-high, then two register stages
  logic hs_s0, vs_s0;
  logic hs_s1, hs_s2, vs_s1, vs_s2;
  logic hs_rise, hs_fall, vs_rise;

  assign hs_s0   = vga_hs ^ ~SYNC_POL;
  assign vs_s0   = vga_vs ^ ~SYNC_POL;
  assign hs_rise = hs_s1 & ~hs_s2;
  assign hs_fall = ~hs_s1 & hs_s2;
  assign vs_rise = vs_s1 & ~vs_s2;

  // Counters and measurement registers
  logic [CW-1:0] h_cnt, w_cnt, v_cnt;
  logic          first_line;
  logic          line_bad;

  logic [CW-1:0] h_cnt_inc;
  logic          ev_hlen, ev_hmiss, line_ev, ev_vover, frame_good;

  assign h_cnt_inc = sat_inc(h_cnt);
  // A measured line whose period is not exactly H_TOTAL
  assign ev_hlen   = hs_rise & ~first_line & (h_cnt_inc != H_T);
  // h_cnt is about to reach H_TOTAL with no hsync edge: missing hsync
  assign ev_hmiss  = ~hs_rise & (h_cnt == H_LAST);
  assign line_ev   = ev_hlen | ev_hmiss;
  // Another line would push the frame past V_TOTAL
  assign ev_vover  = hs_rise & ~vs_rise & (v_cnt >= V_T);
  // Judged at a vsync edge; includes a line event in that same cycle
  assign frame_good = (v_cnt == V_T) & ~line_bad & ~line_ev;

  // FSM
  state_t     state, state_nxt;
  logic [3:0] good_cnt, good_nxt, good_inc;
  logic       err_nxt, fs_nxt;

  assign good_inc = good_cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_nxt   = 1'b0;
    fs_nxt    = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_rise) begin
          state_nxt = MEASURE;
          good_nxt  = 4'd0;
        end
      end
      MEASURE: begin
        if (vs_rise) begin
          if (frame_good) begin
            good_nxt = good_inc;
            if (good_inc == LOCK_N) state_nxt = LOCKED;
          end else begin
            good_nxt = 4'd0;
          end
        end
      end
      LOCKED: begin
        // Error takes priority over the frame_start pulse
        if (line_ev || ev_vover || (vs_rise && (v_cnt != V_T))) begin
          err_nxt   = 1'b1;
          state_nxt = MEASURE;
          good_nxt  = 4'd0;
        end else if (vs_rise) begin
          fs_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = SEARCH;
        good_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      good_cnt    <= 4'd0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      good_cnt    <= good_nxt;
      locked      <= (state_nxt == LOCKED);
      sync_err    <= err_nxt;
      frame_start <= fs_nxt;
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1      <= 1'b0;
      hs_s2      <= 1'b0;
      vs_s1      <= 1'b0;
      vs_s2      <= 1'b0;
      h_cnt      <= '0;
      w_cnt      <= '0;
      v_cnt      <= '0;
      first_line <= 1'b1;
      line_bad   <= 1'b0;
      hc_meas    <= '0;
      hs_width   <= '0;
      vc_meas    <= '0;
    end else begin
      hs_s1 <= hs_s0;
      hs_s2 <= hs_s1;
      vs_s1 <= vs_s0;
      vs_s2 <= vs_s1;

      h_cnt <= hs_rise ? '0 : h_cnt_inc;
      if (hs_rise) first_line <= 1'b0;
      if (hs_rise && !first_line) hc_meas <= h_cnt_inc;

      if (hs_rise)    w_cnt <= '0;
      else if (hs_s1) w_cnt <= sat_inc(w_cnt);
      if (hs_fall) hs_width <= sat_inc(w_cnt);

      // A coincident hsync edge is the first line of the new frame
      if (vs_rise) begin
        vc_meas <= v_cnt;
        v_cnt   <= hs_rise ? ONE : '0;
      end else if (hs_rise) begin
        v_cnt <= sat_inc(v_cnt);
      end

      line_bad <= vs_rise ? 1'b0 : (line_bad | line_ev);
    end
  end

  assign h_pos = locked ? h_cnt : '0;
  assign v_pos = locked ? v_cnt : '0;

endmodule
